// File: rtl/mac3_pkg.sv
// Shared definitions for the 3x3 multiply-accumulate block: FSM encoding
// and default sizing constants.
package mac3_pkg;

    // Smallest accumulator width that cannot wrap for a given frame length.
    function automatic int minAccW(input int maxTerms);
        return $clog2(49 * maxTerms + 1);
    endfunction

    localparam int MAX_TERMS_DEF = 16;
    localparam int ACC_W_DEF     = minAccW(MAX_TERMS_DEF);
    localparam int PROD_W        = 6;
    localparam int COUNT_W       = 5;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/mac3_accum_if.sv
// Operand-in / result-out handshake bundle for mac3_accum.
interface mac3_accum_if #(
    parameter int ACC_W = mac3_pkg::ACC_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       a;
    logic [2:0]       b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [4:0]       out_count;
    logic             out_len_err;

    modport master (
        output in_valid, a, b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_len_err
    );

    modport slave (
        input  in_valid, a, b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_len_err
    );
endinterface

// File: rtl/mac3_accum_mult3_core.sv
// Purely combinational 3x3 unsigned multiplier feeding the product register.
module mult3_core (
    input  logic [2:0] a_i,
    input  logic [2:0] b_i,
    output logic [5:0] prod_o
);
    assign prod_o = {3'b000, a_i} * {3'b000, b_i};
endmodule

// File: rtl/mac3_accum.sv
// Frame-based multiply-accumulate: registers a*b per accepted beat, sums it
// one cycle later, and presents the frame total until downstream takes it.
module mac3_accum
    import mac3_pkg::*;
#(
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int ACC_W     = ACC_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mac3_accum_if.slave   bus
);

    state_e               state_q, state_d;
    logic [PROD_W-1:0]    product;
    logic [PROD_W-1:0]    prod_q, prod_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 lenErr_q, lenErr_d;
    logic                 inReady;
    logic                 accept;
    logic                 atLimit;

    mult3_core u_mult (
        .a_i    (bus.a),
        .b_i    (bus.b),
        .prod_o (product)
    );

    assign inReady = (state_q == ST_ACC);
    assign accept  = bus.in_valid && inReady;
    assign atLimit = (count_q == COUNT_W'(MAX_TERMS - 1));

    assign bus.in_ready    = inReady;
    assign bus.out_valid   = (state_q == ST_DONE);
    assign bus.out_sum     = acc_q;
    assign bus.out_count   = count_q;
    assign bus.out_len_err = lenErr_q;

    // The product register idles at zero, so the accumulator can add it
    // unconditionally without disturbing a held result.
    always_comb begin
        state_d  = state_q;
        prod_d   = '0;
        acc_d    = acc_q + ACC_W'(prod_q);
        count_d  = count_q;
        lenErr_d = lenErr_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    prod_d  = product;
                    count_d = count_q + COUNT_W'(1);
                    if (bus.in_last || atLimit) begin
                        state_d  = ST_DRAIN;
                        lenErr_d = !bus.in_last;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d  = ST_ACC;
                    acc_d    = '0;
                    count_d  = '0;
                    lenErr_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ACC;
            prod_q   <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            lenErr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            lenErr_q <= lenErr_d;
        end
    end

endmodule

// File: tb/tb_mac3_accum.sv
// Directed and randomized frame checks for mac3_accum using hand-computed sums.
module tb_mac3_accum;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    mac3_accum_if #(.ACC_W(10)) bus ();

    mac3_accum #(
        .MAX_TERMS (16),
        .ACC_W     (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b, input logic last);
        checkOutput("beatReady", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic checkResult(input string tag, input int sum, input int count, input logic err);
        checkOutput({tag, "Valid"}, 32'(bus.out_valid), 1);
        checkOutput({tag, "Sum"}, 32'(bus.out_sum), sum);
        checkOutput({tag, "Count"}, 32'(bus.out_count), count);
        checkOutput({tag, "Err"}, 32'(bus.out_len_err), 32'(err));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "Ready"}, 32'(bus.in_ready), 1);
        checkOutput({tag, "Valid"}, 32'(bus.out_valid), 0);
        checkOutput({tag, "Sum"}, 32'(bus.out_sum), 0);
        checkOutput({tag, "Count"}, 32'(bus.out_count), 0);
        checkOutput({tag, "Err"}, 32'(bus.out_len_err), 0);
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput("hsValid", 32'(bus.out_valid), 0);
        checkOutput("hsReady", 32'(bus.in_ready), 1);
    endtask

    task automatic waitOutValid(input int maxCycles);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput("waitValid", 32'(bus.out_valid), 1);
    endtask

    initial begin
        int a, b, n, expSum, gaps;
        logic dropLast;
        testsRun      = 0;
        testsFailed   = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 3'd0;
        bus.b         = 3'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        checkIdle("reset");
        rst = 1'b0;

        // Single term 7x7: DRAIN for one cycle, then result.
        applyStimulus(3'd7, 3'd7, 1'b1);
        checkOutput("singleDrainValid", 32'(bus.out_valid), 0);
        checkOutput("singleDrainReady", 32'(bus.in_ready), 0);
        tick();
        checkResult("single", 49, 1, 1'b0);
        checkOutput("singleDoneReady", 32'(bus.in_ready), 0);
        handshake();

        // Burst 2x3, 5x1, 4x4 -> 27.
        applyStimulus(3'd2, 3'd3, 1'b0);
        applyStimulus(3'd5, 3'd1, 1'b0);
        applyStimulus(3'd4, 3'd4, 1'b1);
        checkOutput("burstDrainReady", 32'(bus.in_ready), 0);
        tick();
        checkOutput("burstDoneReady", 32'(bus.in_ready), 0);
        checkResult("burst", 27, 3, 1'b0);
        handshake();

        // Sixteen 7x7 without in_last: force-closed with length error.
        for (int i = 0; i < 16; i++) applyStimulus(3'd7, 3'd7, 1'b0);
        checkOutput("maxDrainReady", 32'(bus.in_ready), 0);
        tick();
        checkResult("maxNoLast", 784, 16, 1'b1);
        handshake();

        // Sixteen 7x7 with in_last on the sixteenth: no length error.
        for (int i = 0; i < 15; i++) applyStimulus(3'd7, 3'd7, 1'b0);
        applyStimulus(3'd7, 3'd7, 1'b1);
        tick();
        checkResult("maxLast", 784, 16, 1'b0);
        handshake();

        // Backpressure with an offered beat that must be ignored.
        applyStimulus(3'd2, 3'd2, 1'b1);
        tick();
        bus.in_valid = 1'b1;
        bus.a        = 3'd7;
        bus.b        = 3'd7;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkResult("hold", 4, 1, 1'b0);
            checkOutput("holdReady", 32'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        handshake();
        applyStimulus(3'd1, 3'd1, 1'b1);
        tick();
        checkResult("afterHold", 1, 1, 1'b0);
        handshake();

        // Reset mid-frame, with a beat offered in the reset cycle.
        applyStimulus(3'd3, 3'd3, 1'b0);
        applyStimulus(3'd2, 3'd2, 1'b0);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 3'd5;
        bus.b        = 3'd5;
        bus.in_last  = 1'b1;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        checkIdle("midReset");
        tick();
        checkIdle("midResetProd");
        applyStimulus(3'd3, 3'd2, 1'b1);
        tick();
        checkResult("postReset", 6, 1, 1'b0);
        handshake();

        // Reset while holding a result in DONE.
        applyStimulus(3'd1, 3'd2, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkIdle("doneReset");

        // Randomized frames with valid gaps and noisy out_ready.
        for (int f = 0; f < 1000; f++) begin
            n        = $urandom_range(1, 16);
            dropLast = (n == 16) && ($urandom_range(0, 1) == 1);
            expSum   = 0;
            for (int t = 0; t < n; t++) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    bus.a         = 3'($urandom_range(0, 7));
                    tick();
                end
                a = $urandom_range(0, 7);
                b = $urandom_range(0, 7);
                expSum += a * b;
                bus.out_ready = 1'($urandom_range(0, 1));
                applyStimulus(3'(a), 3'(b), (t == n - 1) && !dropLast);
                bus.out_ready = 1'b0;
            end
            waitOutValid(4);
            repeat ($urandom_range(0, 3)) tick();
            checkResult("rand", expSum, n, dropLast);
            handshake();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mac3_accum.md
MAC3_ACCUM -- requirements
Module: mac3_accum

Interface
REQ-001 Parameter MAX_TERMS, default 16: maximum products per frame, range 2..16.
REQ-002 Parameter ACC_W, default 10: accumulator width, at least ceil(log2(49*MAX_TERMS+1)).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat valid.
REQ-006 in_ready  output  1  block can accept a beat.
REQ-007 a  input  3  unsigned multiplicand.
REQ-008 b  input  3  unsigned multiplier.
REQ-009 in_last  input  1  beat is the final term of the frame.
REQ-010 out_valid  output  1  frame result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_sum  output  ACC_W  sum of the frame's products.
REQ-013 out_count  output  5  number of terms in the frame, 1..MAX_TERMS.
REQ-014 out_len_err  output  1  frame was force-closed at MAX_TERMS without in_last.

Function
REQ-015 A beat is accepted when in_valid and in_ready are both high in the same cycle; otherwise it is not accepted.
REQ-016 The product a*b (6-bit, unsigned, 0..49) of an accepted beat shall be registered in the cycle of acceptance and added to the accumulator on the following cycle.
REQ-017 FSM states: ACC, DRAIN, DONE.
REQ-018 ACC: in_ready=1 and out_valid=0; the block moves to DRAIN on acceptance of a beat with in_last=1, or on acceptance of the MAX_TERMS-th beat.
REQ-019 DRAIN: in_ready=0; the last product is added; the block moves unconditionally to DONE after one cycle.
REQ-020 DONE: out_valid=1 and in_ready=0; out_sum, out_count and out_len_err are held stable; on out_ready=1 the block moves to ACC with the accumulator, term count and error flag cleared in the same edge.
REQ-021 Latency: when the final beat is accepted at edge t, out_valid shall be high from edge t+2.
REQ-022 Throughput: back-to-back beats are accepted every cycle in ACC, and a new frame's first beat is accepted in the cycle after the DONE handshake.
REQ-023 out_len_err=1 only when the MAX_TERMS-th beat is accepted with in_last=0; a beat with in_last=1 at the MAX_TERMS-th position sets out_len_err=0.
REQ-024 The accumulator shall never wrap under the ACC_W rule; no saturation logic is required.
REQ-025 Operand changes while in_valid=0, or while in_ready=0, have no effect on state.
REQ-026 out_ready while out_valid=0 is ignored.

Reset
REQ-027 Reset dominates all other inputs in the same cycle.
REQ-028 After reset: state=ACC, accumulator=0, term count=0, product register=0, in_ready=1, out_valid=0, out_sum=0, out_count=0, out_len_err=0.
REQ-029 Reset in any state, including mid-frame, in DRAIN or in DONE, discards the partial or held result with no output handshake.

Structure
REQ-030 State encoding and the default MAX_TERMS/ACC_W constants shall reside in shared package mac3_pkg.
REQ-031 The 3x3 unsigned multiply shall be a separate combinational sub-module, mult3_core, instantiated once; the product register and all control stay in mac3_accum.

Verification
REQ-032 Single term: a=7, b=7, in_last=1 accepted at edge t -> out_valid at t+2, out_sum=49, out_count=1, out_len_err=0.
REQ-033 Burst of 3 consecutive beats (2x3, 5x1, 4x4, last on the third) -> out_sum=27, out_count=3, in_ready=0 from the edge after the last beat until the handshake.
REQ-034 16 beats of 7x7 with in_last=0 throughout -> out_sum=784, out_count=16, out_len_err=1; a 16th beat with in_last=1 gives out_len_err=0.
REQ-035 Backpressure: out_ready held low for 5 cycles in DONE -> outputs stable; a beat offered during DONE is not accepted; after the handshake, the next frame 1x1 returns out_sum=1.
REQ-036 Reset asserted after 2 beats of a 4-beat frame -> all REQ-028 values next cycle; a following frame 3x2 (last) returns out_sum=6, out_count=1.
REQ-037 Random valid gaps and random out_ready over 1000 frames -> each result matches a reference sum and term count.
